// File: rtl/rst_seq_gen_if.sv
// Signal bundle between the reset sequencer (slave) and the block driving requests /
// consuming resets (master). sw_rst_req_i exists only when RST_SEQ_SWRST_EN is defined.
interface rst_seq_gen_if #(
    parameter int N_CH = 4
);
    logic            ext_rst_req_i;
    logic [N_CH-1:0] rst_n_o;
    logic            rst_done_o;
    logic [1:0]      rst_cause_o;
`ifdef RST_SEQ_SWRST_EN
    logic            sw_rst_req_i;

    modport master (
        output ext_rst_req_i,
        output sw_rst_req_i,
        input  rst_n_o,
        input  rst_done_o,
        input  rst_cause_o
    );
    modport slave (
        input  ext_rst_req_i,
        input  sw_rst_req_i,
        output rst_n_o,
        output rst_done_o,
        output rst_cause_o
    );
`else
    modport master (
        output ext_rst_req_i,
        input  rst_n_o,
        input  rst_done_o,
        input  rst_cause_o
    );
    modport slave (
        input  ext_rst_req_i,
        output rst_n_o,
        output rst_done_o,
        output rst_cause_o
    );
`endif
endinterface

// File: rtl/rst_seq_gen.sv
// Reset sequencer: stretches reset, then releases N_CH channels in staggered index order.
// Optional synchronous software reset request enabled by defining RST_SEQ_SWRST_EN.
module rst_seq_gen #(
    parameter int N_CH      = 4,
    parameter int STRETCH   = 16,
    parameter int STAGE_GAP = 8,
    parameter int DEB_CYC   = 4
) (
    input  logic         IO_CLK,
    input  logic         IO_RST_N,
    rst_seq_gen_if.slave rst_bus
);
    localparam int MAX_AB = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;
    localparam int MAX_C  = (MAX_AB > DEB_CYC) ? MAX_AB : DEB_CYC;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam logic [1:0] S_ASSERT  = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    generate
        if (N_CH < 1 || STRETCH < 1 || STAGE_GAP < 1 || DEB_CYC < 1) begin : g_bad_param
            $error("rst_seq_gen: all parameters must be >= 1");
        end
    endgenerate

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       state;
    logic [N_CH-1:0]  rst_n_q;
    logic             done_q;
    logic [1:0]       cause_q;
    logic             accepted;
    logic             sw_req;
    logic             trigger;
    logic [N_CH-1:0]  first_mask;
    logic [N_CH-1:0]  next_mask;

    // Releasing a channel shifts in a one at bit 0, so channels only ever rise in index order.
    function automatic logic [N_CH-1:0] release_next(input logic [N_CH-1:0] mask);
        return (mask << 1) | N_CH'(1);
    endfunction

    always_comb begin
        accepted   = sync2 && (deb_cnt == CNT_W'(DEB_CYC));
`ifdef RST_SEQ_SWRST_EN
        sw_req     = rst_bus.sw_rst_req_i;
`else
        sw_req     = 1'b0;
`endif
        trigger    = accepted | sw_req;
        first_mask = release_next('0);
        next_mask  = release_next(rst_n_q);
    end

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= rst_bus.ext_rst_req_i;
            sync2 <= sync1;
            if (!sync2) begin
                deb_cnt <= '0;
            end else if (deb_cnt != CNT_W'(DEB_CYC)) begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            state   <= S_ASSERT;
            cnt     <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            cause_q <= CAUSE_POR;
        end else if (trigger) begin
            // External request takes priority in the reported cause.
            state   <= S_ASSERT;
            cnt     <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            cause_q <= accepted ? CAUSE_EXT : CAUSE_SW;
        end else begin
            case (state)
                S_ASSERT: begin
                    if (cnt == CNT_W'(STRETCH - 1)) begin
                        cnt     <= '0;
                        rst_n_q <= first_mask;
                        if (&first_mask) begin
                            state  <= S_RUN;
                            done_q <= 1'b1;
                        end else begin
                            state  <= S_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (cnt == CNT_W'(STAGE_GAP - 1)) begin
                        cnt     <= '0;
                        rst_n_q <= next_mask;
                        if (&next_mask) begin
                            state  <= S_RUN;
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state   <= S_ASSERT;
                    cnt     <= '0;
                    rst_n_q <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rst_bus.rst_n_o     = rst_n_q;
    assign rst_bus.rst_done_o  = done_q;
    assign rst_bus.rst_cause_o = cause_q;
endmodule

// File: tb/tb_rst_seq_gen.sv
// Testbench for rst_seq_gen: behavioural model (time since last restart, run length of
// sampled request) checked every cycle, plus literal timing points. Honors RST_SEQ_SWRST_EN.
module tb_rst_seq_gen;
    localparam int N_CH      = 4;
    localparam int STRETCH   = 16;
    localparam int STAGE_GAP = 8;
    localparam int DEB_CYC   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rst_seq_gen_if #(.N_CH(N_CH)) rst_bus ();

    rst_seq_gen #(
        .N_CH(N_CH), .STRETCH(STRETCH), .STAGE_GAP(STAGE_GAP), .DEB_CYC(DEB_CYC)
    ) dut (
        .IO_CLK(clk),
        .IO_RST_N(rst_n),
        .rst_bus(rst_bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: r1/r2 = length of the run of high request samples ending one/two samples ago;
    // t = edges since the last restart of the sequence.
    int         r1 = 0;
    int         r2 = 0;
    int         t  = 0;
    logic [1:0] m_cause = 2'b00;
    logic       m_sw;
    logic       m_acc;
    logic [N_CH-1:0] exp_rst;
    logic            exp_done;

    always_comb begin
`ifdef RST_SEQ_SWRST_EN
        m_sw = rst_bus.sw_rst_req_i;
`else
        m_sw = 1'b0;
`endif
        m_acc = (r2 >= DEB_CYC + 1);
        exp_rst = '0;
        for (int k = 0; k < N_CH; k++) exp_rst[k] = (t >= STRETCH + k * STAGE_GAP);
        exp_done = (t >= STRETCH + (N_CH - 1) * STAGE_GAP);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1 <= 0; r2 <= 0; t <= 0; m_cause <= 2'b00;
        end else begin
            r2 <= r1;
            r1 <= rst_bus.ext_rst_req_i ? ((r1 < 1000) ? r1 + 1 : r1) : 0;
            if (m_acc || m_sw) begin
                t <= 0;
                m_cause <= m_acc ? 2'b01 : 2'b10;
            end else if (t < 100000) begin
                t <= t + 1;
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if ({rst_bus.rst_n_o, rst_bus.rst_done_o, rst_bus.rst_cause_o} !== {exp_rst, exp_done, m_cause}) begin
            miscompares++;
            $display("FAIL cycle_model @%0t: got rst_n=%b done=%b cause=%b, want rst_n=%b done=%b cause=%b",
                     $time, rst_bus.rst_n_o, rst_bus.rst_done_o, rst_bus.rst_cause_o, exp_rst, exp_done, m_cause);
        end
    end

    task automatic lit(input string nm, input logic [N_CH+2:0] want);
        vectors++;
        if ({rst_bus.rst_n_o, rst_bus.rst_done_o, rst_bus.rst_cause_o} !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: dut got=%b want=%b", nm, $time,
                     {rst_bus.rst_n_o, rst_bus.rst_done_o, rst_bus.rst_cause_o}, want);
        end
        vectors++;
        if ({exp_rst, exp_done, m_cause} !== want) begin
            miscompares++;
            $display("FAIL %s_model @%0t: model got=%b want=%b", nm, $time, {exp_rst, exp_done, m_cause}, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called just after IO_RST_N deasserts in the low clock phase; the next posedge is edge 1.
    task automatic por_seq(input string tag);
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            case (e)
                15: lit({tag, "_e15"}, {4'b0000, 1'b0, 2'b00});
                16: lit({tag, "_e16"}, {4'b0001, 1'b0, 2'b00});
                24: lit({tag, "_e24"}, {4'b0011, 1'b0, 2'b00});
                32: lit({tag, "_e32"}, {4'b0111, 1'b0, 2'b00});
                39: lit({tag, "_e39"}, {4'b0111, 1'b0, 2'b00});
                40: lit({tag, "_e40"}, {4'b1111, 1'b1, 2'b00});
                default: ;
            endcase
        end
    endtask

    initial begin
        int ext_left;
        int rst_left;
        rst_bus.ext_rst_req_i = 1'b0;
`ifdef RST_SEQ_SWRST_EN
        rst_bus.sw_rst_req_i = 1'b0;
`endif
        cyc(3);
        lit("reset_hold", {4'b0000, 1'b0, 2'b00});
        #1 rst_n = 1'b1;
        por_seq("por");
        cyc(5);

        // Short glitch is ignored; a request seen for DEB_CYC+1 samples fires at edge 7.
        rst_bus.ext_rst_req_i = 1'b1;
        cyc(DEB_CYC - 1);
        rst_bus.ext_rst_req_i = 1'b0;
        cyc(10);
        lit("glitch_ignored", {4'b1111, 1'b1, 2'b00});
        rst_bus.ext_rst_req_i = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == 5) rst_bus.ext_rst_req_i = 1'b0;
            if (e == 6) lit("pulse_e6", {4'b1111, 1'b1, 2'b00});
            if (e == 7) lit("pulse_e7", {4'b0000, 1'b0, 2'b01});
        end
        cyc(60);

        // Held request keeps everything low; release timed from the falling request.
        rst_bus.ext_rst_req_i = 1'b1;
        cyc(10);
        lit("held_low", {4'b0000, 1'b0, 2'b01});
        cyc(10);
        rst_bus.ext_rst_req_i = 1'b0;
        for (int j = 1; j <= 42; j++) begin
            @(negedge clk);
            case (j)
                17: lit("held_j17", {4'b0000, 1'b0, 2'b01});
                18: lit("held_j18", {4'b0001, 1'b0, 2'b01});
                41: lit("held_j41", {4'b0111, 1'b0, 2'b01});
                42: lit("held_j42", {4'b1111, 1'b1, 2'b01});
                default: ;
            endcase
        end
        cyc(5);

        // Abort in RELEASE after ch1 is up, then a full restart.
        rst_bus.ext_rst_req_i = 1'b1;
        cyc(6);
        rst_bus.ext_rst_req_i = 1'b0;
        for (int j = 1; j <= 74; j++) begin
            @(negedge clk);
            case (j)
                26: begin
                    lit("abort_j26", {4'b0011, 1'b0, 2'b01});
                    rst_bus.ext_rst_req_i = 1'b1;
                end
                32: begin
                    lit("abort_j32", {4'b0011, 1'b0, 2'b01});
                    rst_bus.ext_rst_req_i = 1'b0;
                end
                33: lit("abort_j33", {4'b0000, 1'b0, 2'b01});
                49: lit("abort_j49", {4'b0000, 1'b0, 2'b01});
                50: lit("abort_j50", {4'b0001, 1'b0, 2'b01});
                74: lit("abort_j74", {4'b1111, 1'b1, 2'b01});
                default: ;
            endcase
        end
        cyc(5);

        // Asynchronous reset in the middle of RELEASE, no clock edge needed.
        rst_bus.ext_rst_req_i = 1'b1;
        cyc(6);
        rst_bus.ext_rst_req_i = 1'b0;
        cyc(26);
        lit("pre_async", {4'b0011, 1'b0, 2'b01});
        #2 rst_n = 1'b0;
        #1 lit("async_drop", {4'b0000, 1'b0, 2'b00});
        cyc(2);
        #1 rst_n = 1'b1;
        por_seq("por2");
        cyc(5);

`ifdef RST_SEQ_SWRST_EN
        rst_bus.sw_rst_req_i = 1'b1;
        @(negedge clk);
        rst_bus.sw_rst_req_i = 1'b0;
        lit("sw_drop", {4'b0000, 1'b0, 2'b10});
        for (int j = 2; j <= 17; j++) begin
            @(negedge clk);
            if (j == 16) lit("sw_j16", {4'b0000, 1'b0, 2'b10});
            if (j == 17) lit("sw_j17", {4'b0001, 1'b0, 2'b10});
        end
        cyc(40);
        rst_bus.ext_rst_req_i = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            if (e == 5) rst_bus.ext_rst_req_i = 1'b0;
            if (e == 6) rst_bus.sw_rst_req_i = 1'b1;
            if (e == 7) begin
                rst_bus.sw_rst_req_i = 1'b0;
                lit("sw_ext_same", {4'b0000, 1'b0, 2'b01});
            end
        end
        cyc(50);
`endif

        // Random bursts of request, occasional sw pulses and board resets.
        ext_left = 0;
        rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ext_left == 0) begin
                rst_bus.ext_rst_req_i = ~rst_bus.ext_rst_req_i;
                ext_left = rst_bus.ext_rst_req_i ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 70));
            end else begin
                ext_left--;
            end
`ifdef RST_SEQ_SWRST_EN
            rst_bus.sw_rst_req_i = ($urandom_range(0, 79) == 0);
`endif
            #1;
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                rst_left = int'($urandom_range(1, 3));
            end
        end
        rst_n = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
